fpu_addsub: RTL and testbench

Parametrised, fully pipelined floating-point adder/subtractor with valid/ready handshaking, generalising the core's single-precision adder to arbitrary exponent/mantissa widths. It adds a per-operation subtract mode, overflow saturation and optional round-to-nearest-even. It sits in the FPU execute stage and accepts one operation per cycle when not back-pressured.

---
 rtl/fpu_addsub.sv | 173 +++++++++++++++++
 tb/tb_fpu_addsub.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_addsub.sv
// fpu_addsub: three-stage pipelined floating-point add/subtract with valid/ready flow control.
// Build with FPU_ADDSUB_ROUND_EN defined for round-to-nearest-even; otherwise results are truncated.
module fpu_addsub #(
   parameter int EW = 8,
   parameter int MW = 23
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [EW+MW:0] x1,
   input  logic [EW+MW:0] x2,
   input  logic           sub,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [EW+MW:0] y
);
   localparam int W   = 1 + EW + MW;
   localparam int AW  = MW + 4;             // hidden, mantissa, guard, round, sticky
   localparam int LW  = MW + 2;             // leading-one window: hidden, mantissa, guard
   localparam int SHW = $clog2(MW + 4);
   localparam int SEW = $clog2(LW) + 1;
   localparam int CW  = (EW + 1 > SEW) ? EW + 1 : SEW;
   localparam logic [EW-1:0] EMAX = '1;

   logic adv;
   assign adv      = ~out_valid | out_ready;
   assign in_ready = adv;

   // ---------------- stage 1: classify, order by magnitude, align ----------------
   logic          s1, s2e, zero1, zero2, inf1, inf2, x1_big;
   logic [EW-1:0] e1, e2, eb_c, es_c;
   logic [MW-1:0] m1, m2, mb_c, ms_c;
   logic          sb_c, ss_c, spec_c;
   logic [W-1:0]  spec_y_c;
   logic [EW:0]   diff_c;
   logic [SHW-1:0] sh_c;
   logic [2*MW+3:0] shifted_c;
   logic [AW-1:0] big_c, small_c;

   assign {s1, e1, m1} = x1;
   assign s2e   = x2[W-1] ^ sub;
   assign e2    = x2[W-2:MW];
   assign m2    = x2[MW-1:0];
   assign zero1 = (e1 == '0);
   assign zero2 = (e2 == '0);
   assign inf1  = (e1 == EMAX);
   assign inf2  = (e2 == EMAX);

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      spec_c   = 1'b1;
      spec_y_c = x1;
      if (inf1)                spec_y_c = {s1, EMAX, {MW{1'b0}}};
      else if (inf2)           spec_y_c = {s2e, EMAX, {MW{1'b0}}};
      else if (zero1 && zero2) spec_y_c = {s1 & s2e, {(EW+MW){1'b0}}};
      else if (zero1)          spec_y_c = {s2e, e2, m2};
      else if (zero2)          spec_y_c = x1;
      else                     spec_c   = 1'b0;
   end

   always_comb begin
      x1_big = ({e1, m1} >= {e2, m2});
      sb_c = s2e; ss_c = s1;  eb_c = e2; es_c = e1; mb_c = m2; ms_c = m1;
      if (x1_big) begin
         sb_c = s1; ss_c = s2e; eb_c = e1; es_c = e2; mb_c = m1; ms_c = m2;
      end
      diff_c    = {1'b0, eb_c} - {1'b0, es_c};
      sh_c      = (int'(diff_c) > MW + 3) ? SHW'(MW + 3) : SHW'(diff_c);
      shifted_c = {1'b1, ms_c, {(MW+3){1'b0}}} >> sh_c;
      big_c     = {1'b1, mb_c, 3'b000};
      small_c   = {shifted_c[2*MW+3:MW+1], |shifted_c[MW:0]};
   end

   logic          v1, p1_spec, p1_sb, p1_ss;
   logic [W-1:0]  p1_spec_y;
   logic [EW-1:0] p1_e;
   logic [AW-1:0] p1_big, p1_small;

   // ---------------- stage 2: magnitude add/subtract ----------------
   logic [AW:0]   sum_c;
   logic [AW-1:0] m_c;
   logic [EW:0]   e_c;

   always_comb begin
      sum_c = (p1_sb == p1_ss) ? ({1'b0, p1_big} + {1'b0, p1_small})
                               : ({1'b0, p1_big} - {1'b0, p1_small});
      m_c   = sum_c[AW-1:0];
      e_c   = {1'b0, p1_e};
      if (sum_c[AW]) begin
         m_c = {sum_c[AW:2], sum_c[1] | sum_c[0]};
         e_c = {1'b0, p1_e} + 1'b1;
      end
   end

   logic          v2, p2_spec, p2_sb, p2_ss;
   logic [W-1:0]  p2_spec_y;
   logic [EW:0]   p2_e;
   logic [AW-1:0] p2_m;

   // ---------------- stage 3: normalise, round, pack ----------------
   logic [CW-1:0] se_c, exp_n_c, exp_r_c;
   logic [MW-1:0] frac_c, frac_out_c;
   logic [MW+1:0] rnd_c;
   logic          inc_c;
   logic [W-1:0]  res_c;

   always_comb begin
      se_c = '0;
      for (int i = 0; i < LW; i++)
         if (p2_m[i+2]) se_c = CW'(LW - 1 - i);
   end

   assign frac_c = MW'((p2_m << se_c) >> 3);

`ifdef FPU_ADDSUB_ROUND_EN
   logic [2:0] grs_c;
   assign grs_c = 3'(p2_m << se_c);
   assign inc_c = grs_c[2] & (grs_c[1] | grs_c[0] | frac_c[0]);
`else
   assign inc_c = 1'b0;
`endif

   // A rounding carry out of the hidden bit leaves 1.000..0, one exponent step higher.
   assign rnd_c      = {1'b0, 1'b1, frac_c} + (MW+2)'(inc_c);
   assign frac_out_c = rnd_c[MW+1] ? rnd_c[MW:1] : rnd_c[MW-1:0];
   assign exp_n_c    = CW'(p2_e) - se_c;
   assign exp_r_c    = exp_n_c + CW'(rnd_c[MW+1]);

   always_comb begin
      res_c = {p2_sb, exp_r_c[EW-1:0], frac_out_c};
      if (p2_spec)                  res_c = p2_spec_y;
      else if (p2_m == '0)          res_c = {p2_sb & p2_ss, {(EW+MW){1'b0}}};
      else if (CW'(p2_e) <= se_c)   res_c = {p2_sb, {(EW+MW){1'b0}}};
      else if (exp_r_c >= CW'(EMAX)) res_c = {p2_sb, EMAX, {MW{1'b0}}};
   end

   // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1        <= 1'b0;
         v2        <= 1'b0;
         out_valid <= 1'b0;
         y         <= '0;
      end else if (adv) begin
         v1        <= in_valid;
         v2        <= v1;
         out_valid <= v2;
         if (v2) y <= res_c;
      end
   end

   // NOTE: datapath registers are deliberately not reset; the valid bits alone qualify them.
   always_ff @(posedge clk) begin
      if (adv && in_valid) begin
         p1_spec   <= spec_c;
         p1_spec_y <= spec_y_c;
         p1_sb     <= sb_c;
         p1_ss     <= ss_c;
         p1_e      <= eb_c;
         p1_big    <= big_c;
         p1_small  <= small_c;
      end
      if (adv && v1) begin
         p2_spec   <= p1_spec;
         p2_spec_y <= p1_spec_y;
         p2_sb     <= p1_sb;
         p2_ss     <= p1_ss;
         p2_e      <= e_c;
         p2_m      <= m_c;
      end
   end
endmodule

// File: tb/tb_fpu_addsub.sv
// tb_fpu_addsub: randomized and directed checks of fpu_addsub against an exact-arithmetic model.
// Honors FPU_ADDSUB_ROUND_EN the same way the design does.
module tb_fpu_addsub;
   localparam int EW = 8;
   localparam int MW = 23;
   localparam int W  = 1 + EW + MW;
   localparam int BW = 300;
   localparam int EMAX_I = (1 << EW) - 1;
`ifdef FPU_ADDSUB_ROUND_EN
   localparam bit ROUND = 1'b1;
`else
   localparam bit ROUND = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid = 1'b0, in_ready, sub = 1'b0, out_valid, out_ready = 1'b1;
   logic [W-1:0] x1 = '0, x2 = '0, y;

   logic h_in_valid = 1'b0, h_in_ready, h_sub = 1'b0, h_out_valid, h_out_ready = 1'b1;
   logic [15:0] h_x1 = '0, h_x2 = '0, h_y;

   int checks = 0;
   int failures = 0;
   logic [W-1:0] exp_q[$];

   always #5 clk = ~clk;

   fpu_addsub #(.EW(EW), .MW(MW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x1(x1), .x2(x2),
      .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .y(y)
   );

   fpu_addsub #(.EW(5), .MW(10)) dut_half (
      .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready), .x1(h_x1), .x2(h_x2),
      .sub(h_sub), .out_valid(h_out_valid), .out_ready(h_out_ready), .y(h_y)
   );

   // Exact sum of the two operand values, then normalised, flushed, rounded and saturated.
   function automatic logic [W-1:0] ref_addsub(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic op_sub);
      logic sa, sb, rs, up;
      int ea, eb, emin, p, e, k;
      logic [BW-1:0] va, vb, r, q, rem, half;
      sa = a[W-1];
      sb = b[W-1] ^ op_sub;
      ea = int'(a[W-2:MW]);
      eb = int'(b[W-2:MW]);
      if (ea == EMAX_I) return {sa, {EW{1'b1}}, {MW{1'b0}}};
      if (eb == EMAX_I) return {sb, {EW{1'b1}}, {MW{1'b0}}};
      if (ea == 0 && eb == 0) return {sa & sb, {(W-1){1'b0}}};
      if (ea == 0) return {sb, b[W-2:0]};
      if (eb == 0) return a;
      emin = (ea < eb) ? ea : eb;
      va = BW'({1'b1, a[MW-1:0]}) << (ea - emin);
      vb = BW'({1'b1, b[MW-1:0]}) << (eb - emin);
      if (sa == sb)     begin r = va + vb; rs = sa; end
      else if (va >= vb) begin r = va - vb; rs = sa; end
      else              begin r = vb - va; rs = sb; end
      if (r == '0) return {sa & sb, {(W-1){1'b0}}};
      p = 0;
      for (int i = 0; i < BW; i++) if (r[i]) p = i;
      e = emin + p - MW;
      if (e <= 0) return {rs, {(W-1){1'b0}}};
      if (p > MW) begin
         k    = p - MW;
         q    = r >> k;
         rem  = r & ((BW'(1) << k) - BW'(1));
         half = BW'(1) << (k - 1);
         up   = ROUND && ((rem > half) || (rem == half && q[0]));
         q    = q + BW'(up);
         if (q[MW+1]) begin
            q = q >> 1;
            e = e + 1;
         end
      end else begin
         q = r << (MW - p);
      end
      if (e >= EMAX_I) return {rs, {EW{1'b1}}, {MW{1'b0}}};
      return {rs, EW'(e), q[MW-1:0]};
   endfunction

   // Operand generator biased toward nearby exponents, cancellation, zeros, infinities and overflow.
   function automatic logic [W-1:0] rand_op(input logic [W-1:0] other);
      logic [W-1:0] r;
      int e;
      r = W'($urandom);
      case ($urandom_range(0, 9))
         0: r[W-2:MW] = '0;
         1: r[W-2:MW] = '1;
         2, 3, 4: begin
            e = int'(other[W-2:MW]) + int'($urandom_range(0, 6)) - 3;
            if (e < 1) e = 1;
            if (e > EMAX_I - 1) e = EMAX_I - 1;
            r[W-2:MW] = EW'(e);
         end
         5: r = {~other[W-1], other[W-2:0]};
         6: r[W-2:MW] = EW'(EMAX_I - 1);
         default: ;
      endcase
      return r;
   endfunction

   task automatic cycle(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic ordy, output logic acc, output logic drn,
                        output logic [W-1:0] yv, output logic ir, output logic ov);
      @(negedge clk);
      in_valid  = iv;
      x1        = a;
      x2        = b;
      sub       = s;
      out_ready = ordy;
      #1;
      ir  = in_ready;
      ov  = out_valid;
      yv  = y;
      acc = iv & in_ready;
      drn = out_valid & ordy;
   endtask

   task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          output logic [W-1:0] res, output int lat);
      logic acc, drn, ir, ov;
      logic [W-1:0] yv;
      res = '0;
      lat = -1;
      cycle(1'b1, a, b, s, 1'b1, acc, drn, yv, ir, ov);
      if (!acc) begin
         lat = -2;
         cycle(1'b0, a, b, s, 1'b1, acc, drn, yv, ir, ov);
         return;
      end
      for (int i = 1; i <= 20; i++) begin
         cycle(1'b0, a, b, s, 1'b1, acc, drn, yv, ir, ov);
         if (ov) begin
            lat = i;
            res = yv;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++;
      if (y !== '0) begin failures++; $display("FAIL reset_y: got %h expected 0", y); end
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
   endtask

   task automatic test_directed();
      logic [W-1:0] va[10], vb[10], ve[10], res;
      logic vs[10];
      int lat;
      va = '{32'h3F800000, 32'h3F800000, 32'hBF800000, 32'h7F7FFFFF, 32'h00000000,
             32'h3F800001, 32'h7F800000, 32'h40000000, 32'h00800000, 32'hC0490FDB};
      vb = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h7F7FFFFF, 32'h40490FDB,
             32'h33800000, 32'h7F800000, 32'h3F800000, 32'h00800001, 32'h0000ABCD};
      vs = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      ve = '{32'h40000000, 32'h00000000, 32'hC0000000, 32'h7F800000, 32'hC0490FDB,
             (ROUND ? 32'h3F800002 : 32'h3F800001), 32'h7F800000, 32'h3F800000,
             32'h80000000, 32'hC0490FDB};
      for (int i = 0; i < 10; i++) begin
         run_one(va[i], vb[i], vs[i], res, lat);
         checks++;
         if (lat != 3) begin failures++; $display("FAIL directed_latency[%0d]: got %0d expected 3", i, lat); end
         checks++;
         if (res !== ve[i]) begin failures++; $display("FAIL directed_y[%0d]: got %h expected %h", i, res, ve[i]); end
      end
   endtask

   task automatic test_back_to_back();
      logic acc, drn, ir, ov, prev_stall;
      logic [W-1:0] yv, prev_y, a, b, e;
      logic s, ordy;
      int sent, got;
      sent = 0; got = 0; prev_stall = 1'b0; prev_y = '0;
      exp_q.delete();
      a = rand_op(W'($urandom)); b = rand_op(a); s = 1'($urandom);
      for (int c = 0; c < 100 && got < 8; c++) begin
         ordy = !(c >= 5 && c < 10);
         cycle(sent < 8, a, b, s, ordy, acc, drn, yv, ir, ov);
         if (ov && !ordy) begin
            checks++;
            if (ir !== 1'b0) begin failures++; $display("FAIL b2b_in_ready_stall: got %b expected 0 (cycle %0d)", ir, c); end
            if (prev_stall) begin
               checks++;
               if (yv !== prev_y) begin failures++; $display("FAIL b2b_y_stable: got %h expected %h", yv, prev_y); end
            end
         end
         prev_stall = ov && !ordy;
         prev_y = yv;
         if (drn) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++; $display("FAIL b2b_extra: got %h expected no output", yv);
            end else begin
               e = exp_q.pop_front();
               got++;
               if (yv !== e) begin failures++; $display("FAIL b2b_y[%0d]: got %h expected %h", got - 1, yv, e); end
            end
         end
         if (acc) begin
            exp_q.push_back(ref_addsub(a, b, s));
            sent++;
            a = rand_op(W'($urandom)); b = rand_op(a); s = 1'($urandom);
         end
      end
      for (int c = 0; c < 5; c++) begin
         cycle(1'b0, a, b, s, 1'b1, acc, drn, yv, ir, ov);
         if (ov) got++;
      end
      checks++;
      if (got != 8) begin failures++; $display("FAIL b2b_count: got %0d expected 8", got); end
   endtask

   task automatic test_random();
      logic acc, drn, ir, ov, iv, ordy, s;
      logic [W-1:0] yv, a, b, e;
      int sent, got, cyc;
      sent = 0; got = 0; cyc = 0;
      exp_q.delete();
      a = rand_op(W'($urandom)); b = rand_op(a); s = 1'($urandom);
      while ((sent < 300 || got < sent) && cyc < 4000) begin
         iv   = (sent < 300) && ($urandom_range(0, 3) != 0);
         ordy = ($urandom_range(0, 3) != 0);
         cycle(iv, a, b, s, ordy, acc, drn, yv, ir, ov);
         if (drn) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++; $display("FAIL random_extra: got %h expected no output", yv);
            end else begin
               e = exp_q.pop_front();
               got++;
               if (yv !== e) begin failures++; $display("FAIL random_y[%0d]: got %h expected %h", got - 1, yv, e); end
            end
         end
         if (acc) begin
            exp_q.push_back(ref_addsub(a, b, s));
            sent++;
            a = rand_op(W'($urandom)); b = rand_op(a); s = 1'($urandom);
         end
         cyc++;
      end
      checks++;
      if (got != 300) begin failures++; $display("FAIL random_count: got %0d expected 300", got); end
   endtask

   task automatic test_reset_midflight();
      logic acc, drn, ir, ov;
      logic [W-1:0] yv;
      int stale;
      for (int i = 0; i < 3; i++)
         cycle(1'b1, 32'h3F800000 + W'(i), 32'h40000000, 1'b0, 1'b1, acc, drn, yv, ir, ov);
      @(negedge clk);
      rst = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL midreset_out_valid: got %b expected 0", out_valid); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL midreset_in_ready: got %b expected 1", in_ready); end
      stale = 0;
      for (int c = 0; c < 10; c++) begin
         cycle(1'b0, '0, '0, 1'b0, 1'b1, acc, drn, yv, ir, ov);
         if (ov) stale++;
      end
      checks++;
      if (stale != 0) begin failures++; $display("FAIL midreset_stale: got %0d results expected 0", stale); end
   endtask

   task automatic test_half();
      logic [15:0] ha[2], hb[2], he[2], res;
      logic hs[2];
      int lat;
      ha = '{16'h3C00, 16'h4000};
      hb = '{16'h3C00, 16'h3C00};
      hs = '{1'b0, 1'b1};
      he = '{16'h4000, 16'h3C00};
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         h_in_valid = 1'b1; h_x1 = ha[i]; h_x2 = hb[i]; h_sub = hs[i]; h_out_ready = 1'b1;
         @(negedge clk);
         h_in_valid = 1'b0;
         lat = -1; res = '0;
         for (int c = 0; c < 10; c++) begin
            #1;
            if (h_out_valid) begin lat = c; res = h_y; break; end
            @(negedge clk);
         end
         checks++;
         if (lat < 0 || res !== he[i]) begin
            failures++; $display("FAIL half_y[%0d]: got %h expected %h (seen=%0d)", i, res, he[i], lat >= 0);
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_random();
      test_reset_midflight();
      test_half();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
